serdesphy_tx_serializer: RTL and testbench

Downstream neighbour of the TX FIFO. Pops 8-bit words from the FIFO and shifts them out one bit per `bit_tick` strobe, LSB first, on a single serial line. Inserts `IDLE_PATTERN` bytes whenever no data is available. Tracks transmitted-byte count and a sticky mid-stream underrun error.

---
 rtl/serdesphy_tx_serializer.sv | 204 ++++++++++++++++++++
 tb/tb_serdesphy_tx_serializer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serdesphy_tx_serializer.sv
// serdesphy_tx_serializer
// Pops bytes from the TX FIFO through a one-entry prefetch buffer and shifts
// them out LSB first, one bit per bit_tick. IDLE_PATTERN bytes fill the line
// whenever no data is pending. Counts completed data bytes and flags a sticky
// underrun when a data stream is broken by an idle byte.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable              0 forces DISABLED (serial_out low, no FIFO reads)
//   bit_tick            one-cycle strobe, advances the line by one bit
//   fifo_data/valid     FIFO read data, valid in the fifo_read cycle
//   fifo_empty          FIFO empty flag
//   fifo_read           registered FIFO read pulse
//   prbs_en             PRBS7 pattern select (optional feature)
//   clear_err           clears underrun (a same-cycle set wins)
//   serial_out          registered serial line
//   in_data             current byte is FIFO data
//   byte_count          completed data bytes, wraps
//   underrun            sticky stream-break flag
//
// Optional feature macro: SERDESPHY_TX_PRBS_EN (PRBS7, x^7+x^6+1, seed 7'h7F).
module serdesphy_tx_serializer #(
  parameter logic [7:0]  IDLE_PATTERN = 8'hAA,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 bit_tick,
  input  logic [7:0]           fifo_data,
  input  logic                 fifo_valid,
  input  logic                 fifo_empty,
  output logic                 fifo_read,
  input  logic                 prbs_en,
  input  logic                 clear_err,
  output logic                 serial_out,
  output logic                 in_data,
  output logic [CNT_WIDTH-1:0] byte_count,
  output logic                 underrun
);

  typedef enum logic [1:0] {ST_DISABLED, ST_IDLE, ST_DATA} state_e;

  state_e               state_q, state_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [7:0]           shift_q, shift_d;
  logic [7:0]           next_byte_q, next_byte_d;
  logic                 next_valid_q, next_valid_d;
  logic                 fifo_read_q, fifo_read_d;
  logic                 serial_q, serial_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 underrun_q, underrun_d;
  logic [1:0]           hold_q, hold_d;
  logic                 active, boundary, capture, gap;

`ifdef SERDESPHY_TX_PRBS_EN
  logic [6:0] lfsr_q, lfsr_d;

  // Eight serial steps of the PRBS7 generator; the first emitted bit lands in bit 0.
  function automatic logic [14:0] prbs8(input logic [6:0] seed);
    logic [6:0] s;
    logic [7:0] b;
    s = seed;
    b = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      b[i] = s[6];
      s    = {s[5:0], s[6] ^ s[5]};
    end
    return {s, b};
  endfunction
`else
  logic unused_prbs;
  assign unused_prbs = prbs_en;
`endif

  assign active   = enable && (state_q != ST_DISABLED) && bit_tick;
  assign boundary = active && (bit_idx_q == 3'd7);
  assign capture  = enable && fifo_read_q && fifo_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_DISABLED;
    else     state_q <= state_d;
  end

  // Next-state logic: changes only at byte boundaries while enabled
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_DISABLED;
    end else if (state_q == ST_DISABLED) begin
      state_d = ST_IDLE;
    end else if (boundary) begin
`ifdef SERDESPHY_TX_PRBS_EN
      if (prbs_en)           state_d = ST_IDLE;
      else
`endif
      if (next_valid_q)      state_d = ST_DATA;
      else                   state_d = ST_IDLE;
    end
  end

  // Output logic
  always_comb begin
    in_data    = (state_q == ST_DATA);
    serial_out = serial_q;
    fifo_read  = fifo_read_q;
    byte_count = cnt_q;
    underrun   = underrun_q;
  end

  // Datapath next-state
  always_comb begin
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    next_byte_d  = next_byte_q;
    next_valid_d = next_valid_q;
    serial_d     = serial_q;
    cnt_d        = cnt_q;
    hold_d       = hold_q;
    gap          = 1'b0;
`ifdef SERDESPHY_TX_PRBS_EN
    lfsr_d       = lfsr_q;
`endif
    if (!enable || state_q == ST_DISABLED) begin
      serial_d     = 1'b0;
      shift_d      = IDLE_PATTERN;
      bit_idx_d    = '0;
      next_valid_d = 1'b0;
`ifdef SERDESPHY_TX_PRBS_EN
      if (enable) lfsr_d = 7'h7F;
`endif
    end else if (bit_tick) begin
      serial_d = shift_q[bit_idx_q];
      if (bit_idx_q != 3'd7) begin
        bit_idx_d = bit_idx_q + 3'd1;
      end else begin
        bit_idx_d = '0;
        if (state_q == ST_DATA) cnt_d = cnt_q + 1'b1;
`ifdef SERDESPHY_TX_PRBS_EN
        if (prbs_en) begin
          {lfsr_d, shift_d} = prbs8(lfsr_q);
        end else
`endif
        if (next_valid_q) begin
          shift_d      = next_byte_q;
          next_valid_d = 1'b0;
        end else begin
          shift_d = IDLE_PATTERN;
          gap     = (state_q == ST_DATA);
        end
      end
    end

    // Capture after the boundary so a same-cycle consume-then-refill leaves next_valid set
    if (capture) begin
      next_byte_d  = fifo_data;
      next_valid_d = 1'b1;
      hold_d       = 2'd2;
    end else if (hold_q != 2'd0) begin
      hold_d = hold_q - 2'd1;
    end

    fifo_read_d = enable && !next_valid_q && !fifo_empty && !fifo_read_q && (hold_q == 2'd0);
`ifdef SERDESPHY_TX_PRBS_EN
    if (prbs_en) fifo_read_d = 1'b0;
`endif

    if (gap)            underrun_d = 1'b1;
    else if (clear_err) underrun_d = 1'b0;
    else                underrun_d = underrun_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx_q    <= '0;
      shift_q      <= IDLE_PATTERN;
      next_byte_q  <= '0;
      next_valid_q <= 1'b0;
      fifo_read_q  <= 1'b0;
      serial_q     <= 1'b0;
      cnt_q        <= '0;
      underrun_q   <= 1'b0;
      hold_q       <= '0;
`ifdef SERDESPHY_TX_PRBS_EN
      lfsr_q       <= 7'h7F;
`endif
    end else begin
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      next_byte_q  <= next_byte_d;
      next_valid_q <= next_valid_d;
      fifo_read_q  <= fifo_read_d;
      serial_q     <= serial_d;
      cnt_q        <= cnt_d;
      underrun_q   <= underrun_d;
      hold_q       <= hold_d;
`ifdef SERDESPHY_TX_PRBS_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

endmodule

// File: tb/tb_serdesphy_tx_serializer.sv
module tb_serdesphy_tx_serializer;

  logic        clk = 1'b0;
  logic        rst, enable, bit_tick, fifo_valid, fifo_read, prbs_en, clear_err;
  logic        serial_out, in_data, underrun;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data  = 8'h00;
  logic [15:0] byte_count;

  int n_cmp = 0;
  int n_bad = 0;

  serdesphy_tx_serializer #(.IDLE_PATTERN(8'hAA), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bit_tick(bit_tick),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_empty(fifo_empty),
    .fifo_read(fifo_read), .prbs_en(prbs_en), .clear_err(clear_err),
    .serial_out(serial_out), .in_data(in_data), .byte_count(byte_count),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // FIFO model: push/flush requests come from the stimulus thread, pops from fifo_read
  logic       push_v = 1'b0, flush = 1'b0;
  logic [7:0] push_b = 8'h00;
  logic [7:0] fq[$];
  int         rd_cnt = 0;
  assign fifo_valid = fifo_read && !fifo_empty;

  always @(posedge clk) begin
    if (flush) fq.delete();
    else if (fifo_read && fq.size() > 0) void'(fq.pop_front());
    if (fifo_read) rd_cnt++;
    if (push_v && !flush) fq.push_back(push_b);
    fifo_empty <= (fq.size() == 0);
    fifo_data  <= (fq.size() > 0) ? fq[0] : 8'h00;
  end

  // Stimulus-side state
  int         nb = 0;
  logic [7:0] cur;
  logic       cur_d;
  logic [7:0] exp_q[$];

  task automatic push(input logic [7:0] b);
    push_v = 1'b1; push_b = b; exp_q.push_back(b);
    @(negedge clk);
    push_v = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; bit_tick = 1'b0; clear_err = 1'b0; prbs_en = 1'b0;
    flush = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    nb = 0; exp_q.delete();
    @(negedge clk);
  endtask

  task automatic go_enable();
    enable = 1'b1; nb = 0;
    @(negedge clk);
  endtask

  // One bit_tick; assembles line bits into bytes (in_data taken at bit 0)
  task automatic tick(input int gap, input logic clr, output logic done,
                      output logic [7:0] b, output logic d);
    bit_tick = 1'b1; clear_err = clr;
    @(posedge clk); #1;
    cur[nb] = serial_out;
    if (nb == 0) cur_d = in_data;
    nb++;
    done = 1'b0; b = cur; d = cur_d;
    if (nb == 8) begin done = 1'b1; nb = 0; end
    @(negedge clk);
    bit_tick = 1'b0; clear_err = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic get_byte(input int gap, output logic [7:0] b, output logic d);
    logic dn;
    dn = 1'b0;
    for (int k = 0; k < 8 && !dn; k++) tick(gap, 1'b0, dn, b, d);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (serial_out !== 1'b0) begin n_bad++; $display("FAIL reset_serial got %b want 0", serial_out); end
    n_cmp++; if (in_data !== 1'b0) begin n_bad++; $display("FAIL reset_in_data got %b want 0", in_data); end
    n_cmp++; if (fifo_read !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_read got %b want 0", fifo_read); end
    n_cmp++; if (byte_count !== 16'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", byte_count); end
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL reset_underrun got %b want 0", underrun); end
  endtask

  task automatic test_idle();
    logic [7:0] b; logic d; int rd0;
    do_reset();
    rd0 = rd_cnt;
    go_enable();
    for (int i = 0; i < 4; i++) begin
      get_byte(4, b, d);
      n_cmp++; if (b !== 8'hAA || d !== 1'b0) begin n_bad++; $display("FAIL idle_byte%0d got %h/%b want aa/0", i, b, d); end
    end
    n_cmp++; if (rd_cnt - rd0 != 0) begin n_bad++; $display("FAIL idle_reads got %0d want 0", rd_cnt - rd0); end
  endtask

  task automatic test_single();
    logic [7:0] b; logic d, dn; int rd0;
    do_reset();
    rd0 = rd_cnt;
    go_enable();
    get_byte(4, b, d);
    tick(4, 1'b0, dn, b, d);
    tick(4, 1'b0, dn, b, d);
    push(8'h3C);
    get_byte(4, b, d);
    n_cmp++; if (b !== 8'hAA || d !== 1'b0) begin n_bad++; $display("FAIL single_pre got %h/%b want aa/0", b, d); end
    get_byte(4, b, d);
    n_cmp++; if (b !== 8'h3C || d !== 1'b1) begin n_bad++; $display("FAIL single_data got %h/%b want 3c/1", b, d); end
    get_byte(4, b, d);
    n_cmp++; if (b !== 8'hAA || d !== 1'b0) begin n_bad++; $display("FAIL single_post got %h/%b want aa/0", b, d); end
    n_cmp++; if (byte_count !== 16'd1) begin n_bad++; $display("FAIL single_count got %0d want 1", byte_count); end
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL single_underrun got %b want 1", underrun); end
    n_cmp++; if (rd_cnt - rd0 != 1) begin n_bad++; $display("FAIL single_reads got %0d want 1", rd_cnt - rd0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b; logic d; int rd0;
    do_reset();
    rd0 = rd_cnt;
    go_enable();
    for (int i = 1; i <= 8; i++) push(8'(i));
    get_byte(2, b, d);
    n_cmp++; if (b !== 8'hAA) begin n_bad++; $display("FAIL b2b_lead got %h want aa", b); end
    for (int i = 1; i <= 8; i++) begin
      get_byte(2, b, d);
      n_cmp++; if (b !== 8'(i) || d !== 1'b1) begin n_bad++; $display("FAIL b2b_byte%0d got %h/%b want %h/1", i, b, d, 8'(i)); end
      n_cmp++; if (byte_count !== 16'(i)) begin n_bad++; $display("FAIL b2b_count%0d got %0d want %0d", i, byte_count, i); end
      n_cmp++; if (underrun !== (i == 8)) begin n_bad++; $display("FAIL b2b_underrun%0d got %b want %b", i, underrun, (i == 8)); end
    end
    n_cmp++; if (rd_cnt - rd0 != 8) begin n_bad++; $display("FAIL b2b_reads got %0d want 8", rd_cnt - rd0); end
  endtask

  task automatic test_disable();
    logic [7:0] b; logic d, dn; int rd0;
    do_reset();
    go_enable();
    push(8'h11);
    push(8'h55);
    get_byte(4, b, d);
    get_byte(4, b, d);
    n_cmp++; if (b !== 8'h11 || d !== 1'b1) begin n_bad++; $display("FAIL dis_first got %h/%b want 11/1", b, d); end
    for (int k = 0; k < 4; k++) tick(4, 1'b0, dn, b, d);
    n_cmp++; if (cur[3:0] !== 4'h5 || cur_d !== 1'b1) begin n_bad++; $display("FAIL dis_partial got %h/%b want 5/1", cur[3:0], cur_d); end
    // Drop enable on a tick edge: the line must go low rather than emit bit 4
    enable = 1'b0; bit_tick = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (serial_out !== 1'b0 || in_data !== 1'b0) begin n_bad++; $display("FAIL dis_line got %b/%b want 0/0", serial_out, in_data); end
    @(negedge clk); bit_tick = 1'b0;
    rd0 = rd_cnt;
    push(8'h77);
    for (int k = 0; k < 6; k++) begin
      bit_tick = 1'b1; @(posedge clk); #1;
      n_cmp++; if (serial_out !== 1'b0) begin n_bad++; $display("FAIL dis_hold%0d got %b want 0", k, serial_out); end
      @(negedge clk); bit_tick = 1'b0; @(negedge clk);
    end
    n_cmp++; if (rd_cnt != rd0) begin n_bad++; $display("FAIL dis_reads got %0d want %0d", rd_cnt, rd0); end
    n_cmp++; if (byte_count !== 16'd1) begin n_bad++; $display("FAIL dis_count got %0d want 1", byte_count); end
    go_enable();
    get_byte(4, b, d);
    n_cmp++; if (b !== 8'hAA || d !== 1'b0) begin n_bad++; $display("FAIL reen_idle got %h/%b want aa/0", b, d); end
    get_byte(4, b, d);
    n_cmp++; if (b !== 8'h77 || d !== 1'b1) begin n_bad++; $display("FAIL reen_data got %h/%b want 77/1", b, d); end
    n_cmp++; if (byte_count !== 16'd2) begin n_bad++; $display("FAIL reen_count got %0d want 2", byte_count); end
  endtask

  task automatic test_clear_err();
    logic [7:0] b; logic d, dn;
    do_reset();
    go_enable();
    push(8'h3C);
    for (int k = 0; k < 3; k++) get_byte(3, b, d);
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL clr_pre got %b want 1", underrun); end
    clear_err = 1'b1; @(posedge clk); #1;
    n_cmp++; if (underrun !== 1'b0) begin n_bad++; $display("FAIL clr_plain got %b want 0", underrun); end
    @(negedge clk); clear_err = 1'b0;
    push(8'h5A);
    get_byte(3, b, d);
    n_cmp++; if (b !== 8'hAA || underrun !== 1'b0) begin n_bad++; $display("FAIL clr_idle got %h/%b want aa/0", b, underrun); end
    for (int k = 0; k < 7; k++) tick(3, 1'b0, dn, b, d);
    tick(3, 1'b1, dn, b, d);
    n_cmp++; if (b !== 8'h5A || d !== 1'b1) begin n_bad++; $display("FAIL clr_data got %h/%b want 5a/1", b, d); end
    n_cmp++; if (underrun !== 1'b1) begin n_bad++; $display("FAIL clr_setwins got %b want 1", underrun); end
  endtask

  task automatic test_random();
    logic [7:0] b; logic d, dn, prev_d, seen_gap; int rd0, ndata, npush, nbytes;
    do_reset();
    rd0 = rd_cnt; ndata = 0; npush = 0; nbytes = 0; prev_d = 1'b0; seen_gap = 1'b0;
    go_enable();
    for (int step = 0; step < 2000 && (nbytes < 40 || exp_q.size() > 0); step++) begin
      if (nbytes < 34 && exp_q.size() < 4 && $urandom_range(0, 5) == 0) begin
        push(8'($urandom)); npush++;
      end
      tick(int'($urandom_range(2, 5)), 1'b0, dn, b, d);
      if (dn) begin
        nbytes++;
        if (d) begin
          ndata++;
          n_cmp++;
          if (exp_q.size() == 0) begin n_bad++; $display("FAIL rnd_extra got %h want none", b); end
          else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (b !== e) begin n_bad++; $display("FAIL rnd_data got %h want %h", b, e); end
          end
          n_cmp++; if (byte_count !== 16'(ndata)) begin n_bad++; $display("FAIL rnd_count got %0d want %0d", byte_count, ndata); end
        end else begin
          seen_gap = seen_gap | prev_d;
          n_cmp++; if (b !== 8'hAA) begin n_bad++; $display("FAIL rnd_idle got %h want aa", b); end
          n_cmp++; if (underrun !== seen_gap) begin n_bad++; $display("FAIL rnd_underrun got %b want %b", underrun, seen_gap); end
        end
        prev_d = d;
      end
    end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_drain got %0d left want 0", exp_q.size()); end
    n_cmp++; if (rd_cnt - rd0 != npush) begin n_bad++; $display("FAIL rnd_reads got %0d want %0d", rd_cnt - rd0, npush); end
  endtask

`ifdef SERDESPHY_TX_PRBS_EN
  // Reference PRBS7 stream: seven seed ones, then y[n] = y[n-7] ^ y[n-6]
  function automatic logic [7:0] prbs_ref(input int j);
    logic y[0:127];
    logic [7:0] r;
    for (int n = 0; n < 128; n++) y[n] = (n < 7) ? 1'b1 : (y[n-7] ^ y[n-6]);
    for (int i = 0; i < 8; i++) r[i] = y[8*j + i];
    return r;
  endfunction

  task automatic test_prbs();
    logic [7:0] b; logic d; int rd0;
    do_reset();
    prbs_en = 1'b1;
    rd0 = rd_cnt;
    push(8'h99);
    go_enable();
    get_byte(3, b, d);
    for (int j = 0; j < 4; j++) begin
      get_byte(3, b, d);
      n_cmp++; if (b !== prbs_ref(j) || d !== 1'b0) begin n_bad++; $display("FAIL prbs_byte%0d got %h/%b want %h/0", j, b, d, prbs_ref(j)); end
    end
    n_cmp++; if (rd_cnt != rd0) begin n_bad++; $display("FAIL prbs_reads got %0d want %0d", rd_cnt, rd0); end
    prbs_en = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; bit_tick = 1'b0; clear_err = 1'b0; prbs_en = 1'b0;
    @(negedge clk);
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_disable();
    test_clear_err();
    test_random();
`ifdef SERDESPHY_TX_PRBS_EN
    test_prbs();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d compared", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
